// File: rtl/ir_array_tracker.sv
// Multi-channel IR reflectance tracker: a shared charge/decay scan with a per-channel decay
// timer, hysteresis classification, debounced black state and black-entry counters.
module ir_array_tracker #(
   parameter int CHANNELS      = 4,
   parameter int TIMEOUT       = 32768,
   parameter int TIME_W        = 16,
   parameter int CHARGE_CYCLES = 500,
   parameter int THRESH_BLACK  = 2000,
   parameter int THRESH_WHITE  = 1000,
   parameter int DEBOUNCE      = 3,
   parameter int COUNT_W       = 8
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        enable,
   input  logic                        clear_counts,
   input  logic [CHANNELS-1:0]         inSignal,
   output logic                        outSignal,
   output logic [CHANNELS-1:0]         hayNegro,
   output logic [CHANNELS*COUNT_W-1:0] conteo,
   output logic [CHANNELS*TIME_W-1:0]  tiempo,
   output logic [CHANNELS-1:0]         count_ovf,
   output logic                        sample_valid
);

   localparam int CHG_W = (CHARGE_CYCLES > 1) ? $clog2(CHARGE_CYCLES) : 1;
   localparam int DB_W  = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
   localparam logic [TIME_W-1:0] T_LAST   = TIME_W'(TIMEOUT - 1);
   localparam logic [CHG_W-1:0]  CHG_LAST = CHG_W'(CHARGE_CYCLES - 1);
   localparam logic [DB_W-1:0]   DB_LAST  = DB_W'(DEBOUNCE - 1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_CHARGE  = 2'd1,
      S_MEASURE = 2'd2,
      S_EVAL    = 2'd3
   } state_t;

   state_t                     r_state;
   state_t                     w_state_nxt;
   logic [CHANNELS-1:0]        r_sync1;
   logic [CHANNELS-1:0]        r_sync2;
   logic [CHG_W-1:0]           r_chg_cnt;
   logic [TIME_W-1:0]          r_timer;
   logic [CHANNELS-1:0]        r_capd;
   logic [TIME_W-1:0]          r_cap [CHANNELS];
   logic [CHANNELS-1:0]        w_cap_now;
   logic                       w_cap_all;
   logic                       r_out;
   logic                       w_out_nxt;
   logic                       r_sv;
   logic                       w_sv_nxt;
   logic [CHANNELS-1:0]        r_raw;
   logic [CHANNELS-1:0]        w_raw_nxt;
   logic [DB_W-1:0]            r_db [CHANNELS];
   logic [DB_W-1:0]            w_db_nxt [CHANNELS];
   logic [CHANNELS-1:0]        r_hay;
   logic [CHANNELS-1:0]        w_hay_nxt;
   logic [CHANNELS*COUNT_W-1:0] r_conteo;
   logic [CHANNELS*COUNT_W-1:0] w_conteo_nxt;
   logic [CHANNELS-1:0]        r_ovf;
   logic [CHANNELS-1:0]        w_ovf_nxt;
   logic [CHANNELS*TIME_W-1:0] r_tiempo;

   assign outSignal    = r_out;
   assign hayNegro     = r_hay;
   assign conteo       = r_conteo;
   assign tiempo       = r_tiempo;
   assign count_ovf    = r_ovf;
   assign sample_valid = r_sv;

   // Two-flop synchroniser on the raw sensor lines
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= inSignal;
         r_sync2 <= r_sync1;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (enable) w_state_nxt = S_CHARGE;
            else        w_state_nxt = S_IDLE;
         end
         S_CHARGE: begin
            if (r_chg_cnt == CHG_LAST) w_state_nxt = S_MEASURE;
            else                       w_state_nxt = S_CHARGE;
         end
         S_MEASURE: begin
            if (w_cap_all) w_state_nxt = S_EVAL;
            else           w_state_nxt = S_MEASURE;
         end
         S_EVAL: begin
            if (enable) w_state_nxt = S_CHARGE;
            else        w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Drive is registered from the next state so it is high exactly during CHARGE
   always_comb begin
      w_out_nxt = 1'b0;
      w_sv_nxt  = 1'b0;
      if (w_state_nxt == S_CHARGE) w_out_nxt = 1'b1;
      else                         w_out_nxt = 1'b0;
      if (r_state == S_EVAL) w_sv_nxt = 1'b1;
      else                   w_sv_nxt = 1'b0;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_out <= 1'b0;
         r_sv  <= 1'b0;
      end else begin
         r_out <= w_out_nxt;
         r_sv  <= w_sv_nxt;
      end
   end

   // At the last timer value every remaining channel is forced to capture TIMEOUT-1
   always_comb begin
      w_cap_now = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (r_state == S_MEASURE && !r_capd[i] && (!r_sync2[i] || r_timer == T_LAST))
            w_cap_now[i] = 1'b1;
         else
            w_cap_now[i] = 1'b0;
      end
      w_cap_all = &(r_capd | w_cap_now);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_chg_cnt <= '0;
         r_timer   <= '0;
         r_capd    <= '0;
         for (int i = 0; i < CHANNELS; i++) r_cap[i] <= '0;
      end else begin
         if (r_state == S_CHARGE) r_chg_cnt <= r_chg_cnt + CHG_W'(1);
         else                     r_chg_cnt <= '0;
         if (r_state == S_MEASURE) begin
            r_timer <= r_timer + TIME_W'(1);
            r_capd  <= r_capd | w_cap_now;
         end else begin
            r_timer <= '0;
            r_capd  <= '0;
         end
         for (int i = 0; i < CHANNELS; i++) begin
            if (w_cap_now[i]) r_cap[i] <= r_timer;
         end
      end
   end

   // Per-channel classification, debounce and counting; clear_counts overrides increments
   always_comb begin
      w_raw_nxt    = r_raw;
      w_hay_nxt    = r_hay;
      w_db_nxt     = r_db;
      w_conteo_nxt = r_conteo;
      w_ovf_nxt    = r_ovf;
      if (r_state == S_EVAL) begin
         for (int i = 0; i < CHANNELS; i++) begin
            if (int'(r_cap[i]) >= THRESH_BLACK)     w_raw_nxt[i] = 1'b1;
            else if (int'(r_cap[i]) < THRESH_WHITE) w_raw_nxt[i] = 1'b0;
            else                                    w_raw_nxt[i] = r_raw[i];
            if (w_raw_nxt[i] != r_hay[i]) begin
               if (r_db[i] == DB_LAST) begin
                  w_db_nxt[i]  = '0;
                  w_hay_nxt[i] = w_raw_nxt[i];
                  if (w_raw_nxt[i]) begin
                     w_conteo_nxt[i*COUNT_W +: COUNT_W] = r_conteo[i*COUNT_W +: COUNT_W] + COUNT_W'(1);
                     if (r_conteo[i*COUNT_W +: COUNT_W] == {COUNT_W{1'b1}}) w_ovf_nxt[i] = 1'b1;
                     else                                                   w_ovf_nxt[i] = r_ovf[i];
                  end else begin
                     w_conteo_nxt[i*COUNT_W +: COUNT_W] = r_conteo[i*COUNT_W +: COUNT_W];
                  end
               end else begin
                  w_db_nxt[i] = r_db[i] + DB_W'(1);
               end
            end else begin
               w_db_nxt[i] = '0;
            end
         end
      end else begin
         w_raw_nxt = r_raw;
      end
      if (clear_counts) begin
         w_conteo_nxt = '0;
         w_ovf_nxt    = '0;
      end else begin
         w_ovf_nxt = w_ovf_nxt;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_raw    <= '0;
         r_hay    <= '0;
         r_conteo <= '0;
         r_ovf    <= '0;
         r_tiempo <= '0;
         for (int i = 0; i < CHANNELS; i++) r_db[i] <= '0;
      end else begin
         r_raw    <= w_raw_nxt;
         r_hay    <= w_hay_nxt;
         r_conteo <= w_conteo_nxt;
         r_ovf    <= w_ovf_nxt;
         for (int i = 0; i < CHANNELS; i++) begin
            r_db[i] <= w_db_nxt[i];
            if (r_state == S_EVAL) r_tiempo[i*TIME_W +: TIME_W] <= r_cap[i];
         end
      end
   end

endmodule

// File: tb/tb_ir_array_tracker.sv
// Directed bench for ir_array_tracker: a sensor model that falls at a chosen synchronised
// decay time, a table of per-scan expectations, and hand-written multi-cycle sequences.
module tb_ir_array_tracker;

   localparam int CH = 2;
   localparam int TW = 16;
   localparam int CW = 4;

   logic            clock = 1'b0;
   logic            reset = 1'b0;
   logic            enable = 1'b0;
   logic            clear_counts = 1'b0;
   logic [CH-1:0]   inSignal = '1;
   logic            outSignal;
   logic [CH-1:0]   hayNegro;
   logic [CH*CW-1:0] conteo;
   logic [CH*TW-1:0] tiempo;
   logic [CH-1:0]   count_ovf;
   logic            sample_valid;

   int n_cmp = 0;
   int n_bad = 0;
   int fall_t0 = 100;
   int fall_t1 = 100;

   ir_array_tracker #(
      .CHANNELS(CH), .TIMEOUT(64), .TIME_W(TW), .CHARGE_CYCLES(4),
      .THRESH_BLACK(40), .THRESH_WHITE(20), .DEBOUNCE(2), .COUNT_W(CW)
   ) dut (
      .clock(clock), .reset(reset), .enable(enable), .clear_counts(clear_counts),
      .inSignal(inSignal), .outSignal(outSignal), .hayNegro(hayNegro), .conteo(conteo),
      .tiempo(tiempo), .count_ovf(count_ovf), .sample_valid(sample_valid)
   );

   always #5 clock = ~clock;

   // Sensor: charged while driven; k counts cycles since drive dropped, and a line goes low
   // at k = T-2 so that the synchronised low is seen at timer value T.
   initial begin
      int k;
      k = 0;
      forever begin
         @(posedge clock);
         #1;
         if (outSignal) begin
            k = 0;
            inSignal = '1;
         end else begin
            inSignal[0] = (k >= fall_t0 - 2) ? 1'b0 : 1'b1;
            inSignal[1] = (k >= fall_t1 - 2) ? 1'b0 : 1'b1;
            k++;
         end
      end
   end

   task automatic chk(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, want %0d", name, act, exp);
      end
   endtask

   task automatic wait_sv();
      int n;
      n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (!sample_valid && n < 400);
      if (!sample_valid) chk("sample_valid_timeout", 0, 1);
   endtask

   task automatic wait_out(input logic v);
      int n;
      n = 0;
      while (outSignal != v && n < 400) begin
         @(negedge clock);
         n++;
      end
      if (outSignal != v) chk("outSignal_timeout", outSignal, v);
   endtask

   task automatic scan(input int a, input int b);
      fall_t0 = a;
      fall_t1 = b;
      wait_sv();
   endtask

   typedef struct {
      int         t0;
      int         t1;
      int         e0;
      int         e1;
      logic [1:0] hay;
      int         c0;
      int         c1;
   } vec_t;

   vec_t tbl [11];

   initial begin
      int cnt;
      int svs;
      int outs;
      tbl[0]  = '{10, 100, 10, 63, 2'b00, 0, 0};
      tbl[1]  = '{10, 100, 10, 63, 2'b10, 0, 1};
      tbl[2]  = '{10, 10,  10, 10, 2'b10, 0, 1};
      tbl[3]  = '{10, 10,  10, 10, 2'b00, 0, 1};
      tbl[4]  = '{100, 10, 63, 10, 2'b00, 0, 1};
      tbl[5]  = '{100, 10, 63, 10, 2'b01, 1, 1};
      for (int i = 6; i < 11; i++) tbl[i] = '{30, 10, 30, 10, 2'b01, 1, 1};

      repeat (3) @(negedge clock);
      chk("rst_out", outSignal, 0);
      chk("rst_hay", hayNegro, 0);
      chk("rst_conteo", conteo, 0);
      chk("rst_tiempo", tiempo, 0);
      chk("rst_ovf", count_ovf, 0);
      chk("rst_sv", sample_valid, 0);
      reset = 1'b1;
      @(negedge clock);
      fall_t0 = tbl[0].t0;
      fall_t1 = tbl[0].t1;
      enable = 1'b1;

      for (int r = 0; r < 11; r++) begin
         scan(tbl[r].t0, tbl[r].t1);
         chk($sformatf("row%0d_tiempo0", r), tiempo[15:0], tbl[r].e0);
         chk($sformatf("row%0d_tiempo1", r), tiempo[31:16], tbl[r].e1);
         chk($sformatf("row%0d_hay", r), hayNegro, tbl[r].hay);
         chk($sformatf("row%0d_conteo0", r), conteo[3:0], tbl[r].c0);
         chk($sformatf("row%0d_conteo1", r), conteo[7:4], tbl[r].c1);
         @(negedge clock);
         chk($sformatf("row%0d_sv_single", r), sample_valid, 0);
      end

      // Fifteen more black entries on ch0 wrap the 4-bit counter
      for (int e = 2; e <= 16; e++) begin
         scan(10, 10);
         scan(10, 10);
         scan(100, 10);
         scan(100, 10);
         chk($sformatf("wrap%0d_conteo0", e), conteo[3:0], e % 16);
         chk($sformatf("wrap%0d_ovf0", e), count_ovf[0], (e == 16) ? 1 : 0);
      end

      // clear_counts held exactly in the EVAL cycle of a 0->1 transition
      scan(10, 10);
      scan(10, 10);
      scan(100, 10);
      fall_t0 = 100;
      wait_out(1'b0);
      repeat (64) @(negedge clock);
      clear_counts = 1'b1;
      @(negedge clock);
      clear_counts = 1'b0;
      chk("clr_sv", sample_valid, 1);
      chk("clr_hay", hayNegro, 2'b01);
      chk("clr_conteo0", conteo[3:0], 0);
      chk("clr_conteo1", conteo[7:4], 0);
      chk("clr_ovf", count_ovf, 0);

      // Early exit: MEASURE 6 cycles + EVAL 1 cycle with drive low
      fall_t0 = 5;
      fall_t1 = 5;
      wait_out(1'b0);
      cnt = 0;
      while (!outSignal && cnt < 200) begin
         cnt++;
         @(negedge clock);
      end
      chk("early_low_cycles", cnt, 7);
      chk("early_sv", sample_valid, 1);
      chk("early_tiempo0", tiempo[15:0], 5);
      chk("early_tiempo1", tiempo[31:16], 5);
      cnt = 0;
      while (outSignal && cnt < 50) begin
         cnt++;
         @(negedge clock);
      end
      chk("charge_cycles", cnt, 4);

      // Reset mid-MEASURE
      repeat (2) @(negedge clock);
      reset = 1'b0;
      #1;
      chk("mrst_out", outSignal, 0);
      chk("mrst_hay", hayNegro, 0);
      chk("mrst_conteo", conteo, 0);
      chk("mrst_tiempo", tiempo, 0);
      chk("mrst_ovf", count_ovf, 0);
      chk("mrst_sv", sample_valid, 0);
      @(negedge clock);
      reset = 1'b1;

      // Reset mid-CHARGE drops the drive without a clock edge
      wait_out(1'b1);
      reset = 1'b0;
      #1;
      chk("crst_out", outSignal, 0);
      @(negedge clock);
      reset = 1'b1;

      // enable dropped mid-CHARGE: scan finishes, one pulse, then IDLE
      wait_out(1'b1);
      @(negedge clock);
      enable = 1'b0;
      wait_sv();
      chk("drop_tiempo0", tiempo[15:0], 5);
      svs = 0;
      outs = 0;
      for (int i = 0; i < 150; i++) begin
         @(negedge clock);
         if (sample_valid) svs++;
         if (outSignal) outs++;
      end
      chk("drop_extra_sv", svs, 0);
      chk("drop_out_high", outs, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/ir_array_tracker.md
Name: ir_array_tracker

Overview:
Multi-channel successor to the single-channel infrared black/white tracker for reflectance sensors. It runs a shared charge/decay scan over CHANNELS sensor inputs and measures each channel's decay time. Each channel is classified with hysteresis and debounce, and black-line entries are counted per channel. It sits between the sensor pins and the NIOS II PIO/register bank.

Parameters:
CHANNELS, 4, number of sensor inputs
TIMEOUT, 32768, maximum decay cycles per scan; must be <= 2^TIME_W
TIME_W, 16, width of each decay-time field
CHARGE_CYCLES, 500, cycles the sensor is driven high before measurement
THRESH_BLACK, 2000, decay time >= this classifies as raw black
THRESH_WHITE, 1000, decay time < this classifies as raw white; must be < THRESH_BLACK
DEBOUNCE, 3, consecutive agreeing scans needed to flip the state (>=1)
COUNT_W, 8, width of each per-channel line counter

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
enable  in  1  1 = run scans continuously
clear_counts  in  1  synchronous clear of conteo and count_ovf
inSignal  in  CHANNELS  raw sensor lines (asynchronous)
outSignal  out  1  sensor charge drive (1 = charging)
hayNegro  out  CHANNELS  debounced black state per channel
conteo  out  CHANNELS*COUNT_W  per-channel count of black entries; channel i occupies bits [i*COUNT_W +: COUNT_W]
tiempo  out  CHANNELS*TIME_W  last decay time per channel, same packing
count_ovf  out  CHANNELS  sticky per-channel counter wrap flag
sample_valid  out  1  one-cycle pulse when tiempo and hayNegro update

Behaviour:
- Reset (reset=0, async): FSM=IDLE; outSignal, hayNegro, conteo, tiempo, count_ovf, sample_valid, debounce counters and raw states all 0.
- inSignal passes through a 2-flop synchroniser per channel. Measured times include this 2-cycle latency; it is not compensated.
- FSM states:
  - IDLE: outSignal=0. enable=1 moves to CHARGE on the next cycle.
  - CHARGE: outSignal=1 for exactly CHARGE_CYCLES cycles, then MEASURE.
  - MEASURE: outSignal=0. Timer t starts at 0 and increments each cycle.
    - For each channel not yet captured, a synchronised low at timer value t latches time=t.
    - Exit to EVAL when all channels are captured, or after the cycle with t=TIMEOUT-1.
    - Uncaptured channels latch TIMEOUT-1.
  - EVAL (1 cycle): registers tiempo, classification, debounce and counters; sample_valid=1 in the following cycle. Then go to CHARGE if enable=1, else IDLE.
- enable deasserted mid-scan: the current scan completes, including the sample_valid pulse, then the FSM goes to IDLE.
- Classification per channel:
  - raw=1 if time >= THRESH_BLACK.
  - raw=0 if time < THRESH_WHITE.
  - Otherwise raw keeps its previous value (hysteresis band).
- Debounce per channel:
  - If raw != hayNegro, increment the disagreement counter; when it reaches DEBOUNCE, hayNegro<=raw and the counter is reset.
  - If raw == hayNegro, the counter resets to 0.
  - DEBOUNCE=1 means hayNegro follows raw each scan.
- Counting:
  - conteo[i] increments by 1 in the cycle hayNegro[i] goes 0->1. A 1->0 transition does not count.
  - Counters wrap 2^COUNT_W-1 -> 0, and the wrap sets count_ovf[i] (sticky).
- clear_counts=1: all conteo and count_ovf become 0 next cycle. If coincident with an increment, the clear wins (result 0). It does not affect hayNegro, tiempo or the FSM.
- Channels are fully independent: simultaneous events on several channels are each handled in the same cycle.
- Reset asserted mid-scan: immediate return to reset values; outSignal drops to 0 asynchronously.

Test Plan:
(All scenarios use CHANNELS=2, CHARGE_CYCLES=4, TIMEOUT=64, THRESH_BLACK=40, THRESH_WHITE=20, DEBOUNCE=2, COUNT_W=4.)
- Basic scan: enable=1; ch0 falls at synchronised t=10, ch1 never falls.
  -> outSignal high for 4 cycles; tiempo0=10, tiempo1=63; sample_valid pulses once per scan.
- Debounce: ch1 at time 63 for 2 consecutive scans.
  -> hayNegro[1] rises only after the 2nd scan; conteo1=1. Returning to 10 for 1 scan leaves hayNegro[1]=1; 2 scans clear it with conteo1 still 1.
- Hysteresis: with ch0 black, time=30 for 5 scans.
  -> hayNegro[0] stays 1 and conteo0 is unchanged.
- Wrap: 16 black entries on ch0.
  -> conteo0=0 and count_ovf[0]=1. clear_counts coincident with a 0->1 transition -> conteo0=0, count_ovf[0]=0.
- Early exit: both channels fall at t=5.
  -> MEASURE lasts 6 cycles; the next CHARGE starts 2 cycles after the last measure cycle.
- Reset mid-MEASURE, and enable dropped mid-CHARGE:
  -> Reset: all outputs 0 immediately. enable drop: the scan completes, one sample_valid, then IDLE with outSignal=0.
